// File: rtl/com_sprom_pkg.sv
// -----------------------------------------------------------------------------
// com_sprom_pkg
// Shared definitions for the single-port ROM read front-end and its helpers.
//   COM_SYS_W            : width of the memory system config bus (sys_cfg)
//   COM_SPROM_RDLAT_MAX  : largest supported ROM shell read latency
//   clog2_min1(n)        : $clog2 clamped to at least 1 (index widths)
// -----------------------------------------------------------------------------
`ifndef COM_SYS_W
`define COM_SYS_W 8
`endif

package com_sprom_pkg;

    localparam int COM_SPROM_RDLAT_MAX = 2;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/com_rr_arb.sv
// -----------------------------------------------------------------------------
// com_rr_arb
// Combinational round-robin arbiter. Priority starts at ptr and wraps modulo N.
// Ports:
//   req     in  N   request vector
//   ptr     in  PW  current highest-priority index
//   adv     in  1   allow the pointer to move past the winner
//   grant   out N   one-hot grant (all zero when no request)
//   ptr_nxt out PW  winner+1 mod N when adv and a grant exists, else ptr
// -----------------------------------------------------------------------------
module com_rr_arb
    import com_sprom_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          adv,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] ptr_nxt
);

    int unsigned idx;
    int unsigned win;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        win   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                win        = idx;
                found      = 1'b1;
            end
        end
        ptr_nxt = (adv && found) ? PW'((win + 1) % N) : ptr;
    end

endmodule

// File: rtl/com_sprom_shell.sv
// -----------------------------------------------------------------------------
// com_sprom_shell
// Behavioural wrapper of the single-port ROM macro. Word a holds
// {16'hA5A5, a[15:0]} resized to DATA_W. Data appears RD_LAT cycles after
// rd_en; RD_LAT=2 adds the macro output register.
// Ports:
//   clk, rst_n  in   clock / asynchronous active-low reset
//   sys_cfg     in   memory system config (macro trim pins, not modelled)
//   rd_en       in   read strobe
//   rd_addr     in   word address
//   rd_data     out  read data, valid RD_LAT cycles after rd_en
// -----------------------------------------------------------------------------
module com_sprom_shell
    import com_sprom_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 64,
    parameter  int RD_LAT   = 1,
    parameter  int MEM_USER = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [`COM_SYS_W-1:0] sys_cfg,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] rom_word;
    logic [DATA_W-1:0] dat_q, dat_d;

    // Config and user field only steer the real macro's trim pins.
    logic cfg_unused;
    assign cfg_unused = ^{sys_cfg, 32'(MEM_USER)};

    assign rom_word = DATA_W'({16'hA5A5, 16'(rd_addr)});

    always_comb begin
        dat_d = rd_en ? rom_word : dat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q <= '0;
        end else begin
            dat_q <= dat_d;
        end
    end

    if (RD_LAT >= COM_SPROM_RDLAT_MAX) begin : g_oreg
        logic [DATA_W-1:0] dat_o_q, dat_o_d;

        always_comb begin
            dat_o_d = dat_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dat_o_q <= '0;
            end else begin
                dat_o_q <= dat_o_d;
            end
        end

        assign rd_data = dat_o_q;
    end else begin : g_noreg
        assign rd_data = dat_q;
    end

endmodule

// File: rtl/com_sprom_arb_rd.sv
// -----------------------------------------------------------------------------
// com_sprom_arb_rd
// Multi-channel read front-end for one single-port ROM. CH_NUM requesters
// share the ROM shell through a round-robin arbiter; each channel has a
// one-entry response buffer so a stalled consumer never blocks the others.
// Addresses >= DEPTH are not sent to the ROM and return rsp_err=1, data 0.
// Ports:
//   clk, rst_n  in   clock / asynchronous active-low reset
//   sys_cfg     in   memory config, forwarded to the shell
//   req_vld     in   [CH_NUM]         request valid per channel
//   req_rdy     out  [CH_NUM]         request accepted (combinational grant)
//   req_addr    in   [CH_NUM*ADDR_W]  channel i at [i*ADDR_W +: ADDR_W]
//   rsp_vld     out  [CH_NUM]         response valid, held until rsp_rdy
//   rsp_rdy     in   [CH_NUM]         response consumed
//   rsp_data    out  [CH_NUM*DATA_W]  read data per channel
//   rsp_err     out  [CH_NUM]         address was out of range
// -----------------------------------------------------------------------------
module com_sprom_arb_rd
    import com_sprom_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 64,
    parameter  int CH_NUM   = 4,
    parameter  int RD_LAT   = 1,
    parameter  int MEM_USER = 0,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int CH_W     = clog2_min1(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [`COM_SYS_W-1:0]    sys_cfg,
    input  logic [CH_NUM-1:0]        req_vld,
    output logic [CH_NUM-1:0]        req_rdy,
    input  logic [CH_NUM*ADDR_W-1:0] req_addr,
    output logic [CH_NUM-1:0]        rsp_vld,
    input  logic [CH_NUM-1:0]        rsp_rdy,
    output logic [CH_NUM*DATA_W-1:0] rsp_data,
    output logic [CH_NUM-1:0]        rsp_err
);

    typedef struct packed {
        logic            vld;
        logic [CH_W-1:0] ch;
        logic            err;
    } tag_t;

    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    // run_q keeps req_rdy low throughout reset without using rst_n combinationally.
    logic                     run_q, run_d;
    logic [CH_NUM-1:0]        busy_q, busy_d;
    logic [CH_W-1:0]          ptr_q, ptr_d;
    tag_t [RD_LAT-1:0]        tag_q, tag_d;
    logic [CH_NUM-1:0]        rsp_vld_q, rsp_vld_d;
    logic [CH_NUM-1:0]        rsp_err_q, rsp_err_d;
    logic [CH_NUM*DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [CH_NUM-1:0] elig;
    logic [CH_NUM-1:0] grant;
    logic [CH_NUM-1:0] rsp_hs;
    logic              acc;
    logic [CH_W-1:0]   acc_ch;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_err;
    logic              rom_rd_en;
    logic [DATA_W-1:0] rom_rd_data;
    tag_t              tag_out;

    assign elig   = req_vld & ~busy_q & {CH_NUM{run_q}};
    assign rsp_hs = rsp_vld_q & rsp_rdy;

    com_rr_arb #(
        .N (CH_NUM)
    ) u_arb (
        .req     (elig),
        .ptr     (ptr_q),
        .adv     (run_q),
        .grant   (grant),
        .ptr_nxt (ptr_d)
    );

    always_comb begin
        acc_ch   = '0;
        acc_addr = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (grant[i]) begin
                acc_ch   = CH_W'(i);
                acc_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        acc       = |grant;
        acc_err   = {1'b0, acc_addr} >= DEPTH_LIM;
        rom_rd_en = acc & ~acc_err;
    end

    com_sprom_shell #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RD_LAT   (RD_LAT),
        .MEM_USER (MEM_USER)
    ) u_shell (
        .clk     (clk),
        .rst_n   (rst_n),
        .sys_cfg (sys_cfg),
        .rd_en   (rom_rd_en),
        .rd_addr (acc_addr),
        .rd_data (rom_rd_data)
    );

    // Tag travels alongside the ROM read so it lines up with rom_rd_data.
    always_comb begin
        tag_d[0] = '{vld: acc, ch: acc_ch, err: acc_err};
        for (int unsigned k = 1; k < RD_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        tag_out = tag_q[RD_LAT-1];
    end

    // A capture and a handshake never hit the same channel in one cycle:
    // the channel stays busy until its buffer is consumed.
    always_comb begin
        rsp_vld_d  = rsp_vld_q;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (rsp_hs[i]) begin
                rsp_vld_d[i]                 = 1'b0;
                rsp_err_d[i]                 = 1'b0;
                rsp_data_d[i*DATA_W +: DATA_W] = '0;
            end
            if (tag_out.vld && (tag_out.ch == CH_W'(i))) begin
                rsp_vld_d[i]                 = 1'b1;
                rsp_err_d[i]                 = tag_out.err;
                rsp_data_d[i*DATA_W +: DATA_W] = tag_out.err ? '0 : rom_rd_data;
            end
        end
        busy_d = (busy_q | grant) & ~rsp_hs;
        run_d  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            busy_q     <= '0;
            ptr_q      <= '0;
            tag_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_err_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            run_q      <= run_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            tag_q      <= tag_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign req_rdy  = grant;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_com_sprom_arb_rd.sv
// -----------------------------------------------------------------------------
// tb_com_sprom_arb_rd
// Main instance: 4 channels, DEPTH=48 (non power of 2), RD_LAT=1.
// Second instance: 2 channels, DEPTH=64, RD_LAT=2.
// -----------------------------------------------------------------------------
`ifndef COM_SYS_W
`define COM_SYS_W 8
`endif

module tb_com_sprom_arb_rd;

    localparam int CH  = 4;
    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int DEP = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [`COM_SYS_W-1:0] sys_cfg;

    logic [CH-1:0]    req_vld, req_rdy, rsp_vld, rsp_rdy, rsp_err;
    logic [CH*AW-1:0] req_addr;
    logic [CH*DW-1:0] rsp_data;

    logic [1:0]    b_req_vld, b_req_rdy, b_rsp_vld, b_rsp_rdy, b_rsp_err;
    logic [2*AW-1:0] b_req_addr;
    logic [2*DW-1:0] b_rsp_data;

    com_sprom_arb_rd #(
        .DATA_W (DW), .DEPTH (DEP), .CH_NUM (CH), .RD_LAT (1), .MEM_USER (0)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .sys_cfg (sys_cfg),
        .req_vld (req_vld), .req_rdy (req_rdy), .req_addr (req_addr),
        .rsp_vld (rsp_vld), .rsp_rdy (rsp_rdy), .rsp_data (rsp_data), .rsp_err (rsp_err)
    );

    com_sprom_arb_rd #(
        .DATA_W (DW), .DEPTH (64), .CH_NUM (2), .RD_LAT (2), .MEM_USER (0)
    ) u_dut2 (
        .clk (clk), .rst_n (rst_n), .sys_cfg (sys_cfg),
        .req_vld (b_req_vld), .req_rdy (b_req_rdy), .req_addr (b_req_addr),
        .rsp_vld (b_rsp_vld), .rsp_rdy (b_rsp_rdy), .rsp_data (b_rsp_data), .rsp_err (b_rsp_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [31:0] rom_model(input int a, input int depth);
        return (a < depth) ? (32'hA5A5_0000 | 32'(a)) : 32'h0;
    endfunction

    typedef struct {
        int          ch;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic sb_push(input int ch, input int a);
        exp_t e;
        e.ch   = ch;
        e.err  = (a >= DEP);
        e.data = rom_model(a, DEP);
        sb.push_back(e);
    endtask

    task automatic sb_pop_check(input int ch);
        bit found;
        found = 1'b0;
        for (int k = 0; k < sb.size(); k++) begin
            if (!found && sb[k].ch == ch) begin
                found = 1'b1;
                check_eq($sformatf("data_ch%0d", ch), 128'(rsp_data[ch*DW +: DW]), 128'(sb[k].data));
                check_eq($sformatf("err_ch%0d", ch), 128'(rsp_err[ch]), 128'(sb[k].err));
                sb.delete(k);
            end
        end
        check_eq($sformatf("sb_hit_ch%0d", ch), 128'(found), 128'(1));
    endtask

    // mode 0: plain, 1: full contention, 2: ch1 backpressure, 3: random rsp_rdy
    task automatic run_phase(input int ncyc, input logic [3:0] en, input logic [3:0] rdy,
                             input int amax, input int mode);
        int          last_acc[4];
        int          exp_ch;
        logic [31:0] hold_d;
        bit          hold_v;
        bit          busy1;
        logic [3:0]  newreq;
        exp_ch = -1;
        hold_d = '0;
        hold_v = 1'b0;
        busy1  = 1'b0;
        for (int ch = 0; ch < CH; ch++) begin
            last_acc[ch] = -1;
            req_addr[ch*AW +: AW] = AW'($urandom_range(0, amax));
        end
        req_vld = en;
        rsp_rdy = rdy;
        for (int c = 0; c < ncyc; c++) begin
            mid();
            newreq = '0;
            if (mode == 1) begin
                check_eq("one_accept_per_cycle", 128'($countones(req_vld & req_rdy)), 128'(1));
                check_eq("rom_rd_en_per_cycle", 128'(u_dut.rom_rd_en), 128'(1));
            end
            for (int ch = 0; ch < CH; ch++) begin
                if (req_vld[ch] && req_rdy[ch]) begin
                    sb_push(ch, int'(req_addr[ch*AW +: AW]));
                    newreq[ch] = 1'b1;
                    if (mode == 1) begin
                        if (exp_ch >= 0) check_eq("rr_order", 128'(ch), 128'(exp_ch));
                        exp_ch = (ch + 1) % CH;
                    end
                    if (mode == 2 && (ch == 0 || ch == 3)) begin
                        if (last_acc[ch] >= 0)
                            check_eq($sformatf("bp_period_ch%0d", ch), 128'(c - last_acc[ch]), 128'(3));
                        last_acc[ch] = c;
                    end
                    if (mode == 2 && ch == 1) busy1 = 1'b1;
                end
            end
            if (mode == 2) begin
                if (busy1 && !newreq[1]) check_eq("bp_rdy1_low", 128'(req_rdy[1]), 128'(0));
                if (hold_v) begin
                    check_eq("bp_hold_vld", 128'(rsp_vld[1]), 128'(1));
                    check_eq("bp_hold_data", 128'(rsp_data[DW +: DW]), 128'(hold_d));
                end else if (rsp_vld[1]) begin
                    hold_v = 1'b1;
                    hold_d = rsp_data[DW +: DW];
                end
            end
            for (int ch = 0; ch < CH; ch++) begin
                if (rsp_vld[ch] && rsp_rdy[ch]) sb_pop_check(ch);
            end
            cyc();
            for (int ch = 0; ch < CH; ch++) begin
                if (newreq[ch]) req_addr[ch*AW +: AW] = AW'($urandom_range(0, amax));
            end
            if (mode == 3) rsp_rdy = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        sys_cfg    = '0;
        req_vld    = '1;
        req_addr   = '0;
        rsp_rdy    = '0;
        b_req_vld  = '0;
        b_req_addr = '0;
        b_rsp_rdy  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_rdy", 128'(req_rdy), 128'(0));
        check_eq("rst_rsp_vld", 128'(rsp_vld), 128'(0));
        check_eq("rst_rsp_err", 128'(rsp_err), 128'(0));
        check_eq("rst_rsp_data", 128'(rsp_data), 128'(0));
        req_vld = '0;
        rst_n   = 1'b1;
        cyc();

        // full contention, in-range addresses
        run_phase(40, 4'b1111, 4'b1111, 47, 1);
        run_phase(8, 4'b0000, 4'b1111, 0, 0);
        // ch1 stalled while ch0/ch3 stream
        run_phase(20, 4'b1011, 4'b1101, 63, 2);
        run_phase(8, 4'b0000, 4'b1111, 0, 0);
        // random traffic with random consumer backpressure
        run_phase(60, 4'b1111, 4'b1111, 63, 3);
        run_phase(8, 4'b0000, 4'b1111, 0, 0);
        check_eq("sb_empty", 128'(sb.size()), 128'(0));

        // single read ch2 addr 5
        req_addr[2*AW +: AW] = 6'd5;
        req_vld = 4'b0100;
        rsp_rdy = 4'b1111;
        mid(); check_eq("single_req_rdy", 128'(req_rdy), 128'(4'b0100));
        cyc(); req_vld = '0;
        mid(); check_eq("single_vld_early", 128'(rsp_vld), 128'(0));
        cyc();
        mid(); check_eq("single_vld", 128'(rsp_vld), 128'(4'b0100));
        check_eq("single_data", 128'(rsp_data[2*DW +: DW]), 128'(32'hA5A5_0005));
        check_eq("single_err", 128'(rsp_err), 128'(0));
        cyc();
        mid(); check_eq("single_drop", 128'(rsp_vld), 128'(0));
        cyc();

        // out of range then last valid word on ch0
        req_addr[0 +: AW] = 6'd50;
        req_vld = 4'b0001;
        mid(); check_eq("oor_req_rdy", 128'(req_rdy), 128'(4'b0001));
        check_eq("oor_rd_en", 128'(u_dut.rom_rd_en), 128'(0));
        cyc(); req_vld = '0;
        mid(); cyc();
        mid(); check_eq("oor_vld", 128'(rsp_vld), 128'(4'b0001));
        check_eq("oor_err", 128'(rsp_err[0]), 128'(1));
        check_eq("oor_data", 128'(rsp_data[0 +: DW]), 128'(0));
        cyc();
        req_addr[0 +: AW] = 6'd47;
        req_vld = 4'b0001;
        mid(); check_eq("last_req_rdy", 128'(req_rdy), 128'(4'b0001));
        check_eq("last_rd_en", 128'(u_dut.rom_rd_en), 128'(1));
        cyc(); req_vld = '0;
        mid(); cyc();
        mid(); check_eq("last_vld", 128'(rsp_vld), 128'(4'b0001));
        check_eq("last_err", 128'(rsp_err[0]), 128'(0));
        check_eq("last_data", 128'(rsp_data[0 +: DW]), 128'(32'hA5A5_002F));
        cyc();

        // RD_LAT=2 instance: latency and back-to-back period
        b_req_addr[0 +: AW] = 6'd9;
        b_req_vld = 2'b01;
        b_rsp_rdy = 2'b11;
        mid(); check_eq("rl2_acc", 128'(b_req_rdy), 128'(2'b01));
        cyc(); b_req_addr[0 +: AW] = 6'd10;
        for (int k = 1; k <= 2; k++) begin
            mid();
            check_eq($sformatf("rl2_vld_t%0d", k), 128'(b_rsp_vld), 128'(0));
            check_eq($sformatf("rl2_rdy_t%0d", k), 128'(b_req_rdy), 128'(0));
            cyc();
        end
        mid(); check_eq("rl2_vld_t3", 128'(b_rsp_vld), 128'(2'b01));
        check_eq("rl2_data", 128'(b_rsp_data[0 +: DW]), 128'(32'hA5A5_0009));
        check_eq("rl2_err", 128'(b_rsp_err), 128'(0));
        check_eq("rl2_rdy_t3", 128'(b_req_rdy), 128'(0));
        cyc();
        mid(); check_eq("rl2_reacc_t4", 128'(b_req_rdy), 128'(2'b01));
        cyc(); b_req_vld = '0;
        cyc(); cyc();
        mid(); check_eq("rl2_vld_2nd", 128'(b_rsp_vld), 128'(2'b01));
        check_eq("rl2_data_2nd", 128'(b_rsp_data[0 +: DW]), 128'(32'hA5A5_000A));
        cyc();

        // reset while ch0 and ch2 reads are in flight
        req_addr[0 +: AW]    = 6'd3;
        req_addr[2*AW +: AW] = 6'd7;
        req_vld = 4'b0101;
        rsp_rdy = 4'b1111;
        mid(); check_eq("mid_rst_acc_a", 128'($countones(req_rdy)), 128'(1));
        cyc();
        mid(); check_eq("mid_rst_acc_b", 128'($countones(req_rdy)), 128'(1));
        cyc();
        rst_n   = 1'b0;
        req_vld = '0;
        #1;
        check_eq("mid_rst_req_rdy", 128'(req_rdy), 128'(0));
        check_eq("mid_rst_rsp_vld", 128'(rsp_vld), 128'(0));
        check_eq("mid_rst_rsp_err", 128'(rsp_err), 128'(0));
        check_eq("mid_rst_rsp_data", 128'(rsp_data), 128'(0));
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            mid(); check_eq("post_rst_no_rsp", 128'(rsp_vld), 128'(0));
            cyc();
        end
        req_vld = 4'b1111;
        mid(); check_eq("post_rst_first_grant", 128'(req_rdy), 128'(4'b0001));
        cyc();
        req_vld = '0;
        repeat (5) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/com_sprom_arb_rd.md
Name: com_sprom_arb_rd

Overview:
- Multi-channel read front-end for one single-port ROM macro.
- CH_NUM independent requesters share one com_sprom_shell through a round-robin arbiter. The shell is instantiated internally and configured with sys_cfg.
- Each channel uses a valid/ready request and response handshake and has a one-entry response buffer, so a stalled consumer never blocks the other channels.
- Out-of-range addresses return an error flag. This supports non-power-of-2 DEPTH.

Parameters:
- DATA_W, 32, ROM word width, range [1:].
- DEPTH, 64, number of ROM words, range [2:]. Need not be a power of 2.
- CH_NUM, 4, number of read channels, range [1:16].
- RD_LAT, 1, ROM shell read latency in cycles, range [1:2]. Passed to the shell; the value 2 selects the shell's output register.
- MEM_USER, 0, memory user field, forwarded to the shell.
- ADDR_W, $clog2(DEPTH), localparam.
- CH_W, (CH_NUM>1)?$clog2(CH_NUM):1, localparam.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sys_cfg  in  `COM_SYS_W  memory system config, passed unchanged to the shell
- req_vld  in  CH_NUM  per-channel read request valid
- req_rdy  out  CH_NUM  per-channel request accepted
- req_addr  in  CH_NUM*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W]
- rsp_vld  out  CH_NUM  per-channel response valid
- rsp_rdy  in  CH_NUM  per-channel response consumed
- rsp_data  out  CH_NUM*DATA_W  per-channel read data
- rsp_err  out  CH_NUM  address was >= DEPTH; rsp_data is 0 in that case

Behaviour:
- Reset (rst_n low, asynchronous):
  - req_rdy, rsp_vld, rsp_err and rsp_data are all 0.
  - Busy flags are cleared, the in-flight pipeline is flushed, and the round-robin pointer is set to 0 (channel 0 highest priority).
- Busy flag per channel:
  - Set on request accept.
  - Cleared on the cycle rsp_vld&rsp_rdy for that channel.
  - At most one outstanding read per channel.
- Eligibility and arbitration:
  - Channel i is eligible when req_vld[i] & ~busy[i].
  - The arbiter grants exactly one eligible channel per cycle, combinationally.
  - Priority order starts at ptr and wraps modulo CH_NUM.
  - req_rdy[i] = grant[i]. req_rdy may depend on req_vld; req_vld must not depend on req_rdy.
  - After an accept of channel g, ptr <= (g+1) mod CH_NUM. With no accept, ptr holds.
- ROM access: the accept cycle T drives the shell's rd_en=1 and rd_addr=req_addr[g]. If the address is out of range, rd_en is 0.
- Tag pipeline: {vld, ch, err} is delayed RD_LAT stages to align with shell rd_data.
- Response capture:
  - At the end of cycle T+RD_LAT the channel's buffer captures the data (or 0 when err=1), and its rsp_err.
  - rsp_vld rises in cycle T+RD_LAT+1, so the request-to-response latency is RD_LAT+1.
- Response hold: rsp_vld, rsp_data and rsp_err stay stable until rsp_rdy. They drop on the next cycle after the handshake.
- Back-to-back on one channel: the buffer clears on the handshake edge. A new request on that channel can be accepted in the cycle after the handshake.
  - Minimum per-channel period is RD_LAT+2 cycles.
  - Aggregate throughput is 1 read per cycle when CH_NUM >= RD_LAT+2.
- Simultaneous events:
  - All channels requesting: grants rotate 0,1,2,...
  - A response handshake and a new accept on different channels in the same cycle are both honoured.
- A stalled rsp_rdy on channel i never blocks the other channels.
- Reset mid-operation drops in-flight reads. No response is produced for them after reset release.
- Width rules:
  - The range check is req_addr >= DEPTH, compared at ADDR_W+1 bits.
  - When DEPTH is a power of 2, err is never set.

Decomposition:
- Package com_sprom_pkg:
  - function clog2_min1(n), used for CH_W.
  - typedef struct packed {logic vld; logic [CH_W-1:0] ch; logic err;} for the tag. CH_W is a module-level localparam, so the struct is declared in the module using the package helper.
  - localparam COM_SPROM_RDLAT_MAX=2.
- Sub-module com_rr_arb #(N): inputs req[N], ptr, adv; outputs grant[N] one-hot, and the next ptr. It is reused by other shared-memory front-ends.
- com_sprom_shell is instantiated once.

Test Plan:
- Single read: CH_NUM=4, RD_LAT=1, ROM[5]=0xA5A5_0005, ch2 requests addr 5 at cycle 10 with rsp_rdy=1. Required: req_rdy[2]=1 at cycle 10, rsp_vld[2]=1 at cycle 12 with rsp_data=0xA5A5_0005, rsp_err=0.
- Full contention: all 4 channels request continuously with rsp_rdy=1. Required: grants in order 0,1,2,3,0,...; one shell rd_en per cycle; every channel gets the ROM value of its own address.
- Backpressure: ch1 has rsp_rdy=0 for 20 cycles while ch0 and ch3 stream. Required: ch1 rsp_vld/rsp_data are held stable; req_rdy[1]=0 while busy; ch0 and ch3 each complete 1 read every 3 cycles.
- Out of range: DEPTH=48, ch0 requests addr 50. Required: shell rd_en stays 0; rsp_vld[0]=1 after 2 cycles with rsp_err=1 and rsp_data=0. Addr 47 returns ROM[47] with rsp_err=0.
- RD_LAT=2: accept at cycle T. Required: rsp_vld rises at T+3; the next request on the same channel is accepted at the earliest at T+4 with rsp_rdy=1.
- Reset mid-flight: rst_n low for 1 cycle, 1 cycle after accepts on ch0 and ch2. Required: all outputs 0 immediately; no rsp_vld appears afterwards; the first post-reset grant goes to ch0 when all channels request.
